// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
//   Shared definitions for the flow-controlled pipeline stage.
//
//   Contents:
//     OCC_W    - width of the occupancy count (0..2 entries)
//     SAT_W    - widest counter the saturating helper handles
//     state_t  - stage state; the encoding equals the number of held entries
//     sat_inc  - saturating increment used by the performance counters
// -----------------------------------------------------------------------------
package pipe_pkg;

   localparam int OCC_W = 2;
   localparam int SAT_W = 64;

   // Encoding doubles as the occupancy value, so occupancy is a plain copy.
   typedef enum logic [OCC_W-1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   // Counters of any width up to SAT_W zero-extend into this function and
   // truncate the result back; the result never exceeds max_value, so the
   // truncation is lossless.
   function automatic logic [SAT_W-1:0] sat_inc(
      input logic [SAT_W-1:0] value,
      input logic [SAT_W-1:0] max_value
   );
      logic [SAT_W-1:0] result;
      if (value >= max_value) begin
         result = max_value;
      end else begin
         result = value + SAT_W'(1);
      end
      return result;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//   Event counter that counts up by one per cycle with inc_i high and sticks
//   at all-ones. Cleared only by reset.
//
//   Parameters:
//     CNT_WIDTH - counter width (1..64)
//   Ports:
//     clk    in   rising-edge clock
//     reset  in   asynchronous active-low reset, clears the count
//     inc_i  in   count this cycle
//     cnt_o  out  current count (registered)
// -----------------------------------------------------------------------------
module sat_counter
   import pipe_pkg::*;
#(
   parameter int CNT_WIDTH = 16
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 inc_i,
   output logic [CNT_WIDTH-1:0] cnt_o
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   logic [CNT_WIDTH-1:0] cnt_reg;
   logic [CNT_WIDTH-1:0] cnt_next;

   always_comb begin
      cnt_next = cnt_reg;
      if (inc_i) begin
         cnt_next = CNT_WIDTH'(sat_inc(SAT_W'(cnt_reg), SAT_W'(CNT_MAX)));
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_next;
      end
   end

   assign cnt_o = cnt_reg;

endmodule

// File: rtl/pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid
//   Flow-controlled pipeline stage register with a two-entry skid buffer.
//   One instance sits on each stage boundary of the MIPS core (IF/ID, ID/EX,
//   EX/MEM); the payload is the packed control + datapath bundle of the stage.
//
//   Storage is a main register (always the oldest entry, drives dn_data_o)
//   and a skid register (second entry, only used while the downstream stage
//   stalls). All outputs come straight from flops, so up_ready_o never
//   depends combinationally on dn_ready_i and stages can be chained freely.
//
//   Parameters:
//     DATA_WIDTH - payload width
//     RESET_DATA - value of both payload registers after reset
//     CNT_WIDTH  - performance counter width (optional feature only)
//
//   Ports:
//     clk          in   rising-edge clock
//     reset        in   asynchronous active-low reset
//     flush_i      in   squash every held entry (synchronous)
//     up_valid_i   in   upstream offers a payload
//     up_ready_o   out  stage accepts a payload this cycle (registered)
//     up_data_i    in   upstream payload
//     dn_valid_o   out  stage presents a payload (registered)
//     dn_ready_i   in   downstream accepts this cycle
//     dn_data_o    out  presented payload (main register)
//     occupancy_o  out  entries held, 0..2 (registered)
//
//   Optional build macro PIPE_STAGE_SKID_PERF_EN adds:
//     stall_cnt_o  out  saturating count of cycles with dn_valid_o & ~dn_ready_i
//     flush_cnt_o  out  saturating count of flushes that squashed an entry
// -----------------------------------------------------------------------------
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_DATA = '0,
   parameter int                    CNT_WIDTH  = 16
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush_i,
   input  logic                  up_valid_i,
   output logic                  up_ready_o,
   input  logic [DATA_WIDTH-1:0] up_data_i,
   output logic                  dn_valid_o,
   input  logic                  dn_ready_i,
   output logic [DATA_WIDTH-1:0] dn_data_o,
   output logic [OCC_W-1:0]      occupancy_o
`ifdef PIPE_STAGE_SKID_PERF_EN
   ,
   output logic [CNT_WIDTH-1:0]  stall_cnt_o,
   output logic [CNT_WIDTH-1:0]  flush_cnt_o
`endif
);

   // Elaboration-time sanity check of the configuration.
   if (DATA_WIDTH < 1 || CNT_WIDTH < 1 || CNT_WIDTH > SAT_W) begin : g_bad_param
      $error("pipe_stage_skid: DATA_WIDTH must be >= 1 and CNT_WIDTH in 1..64");
   end

   // --------------------------------------------------------------------------
   // State and storage
   // --------------------------------------------------------------------------
   state_t                state_reg;
   state_t                state_next;
   logic [DATA_WIDTH-1:0] main_reg;
   logic [DATA_WIDTH-1:0] main_next;
   logic [DATA_WIDTH-1:0] skid_reg;
   logic [DATA_WIDTH-1:0] skid_next;

   // Output flags are separate flops loaded from state_next, so they are
   // glitch-free and valid in the same cycle the state changes.
   logic                  dn_valid_reg;
   logic                  dn_valid_next;
   logic                  up_ready_reg;
   logic                  up_ready_next;
   logic [OCC_W-1:0]      occ_reg;
   logic [OCC_W-1:0]      occ_next;

   logic                  up_xfer;
   logic                  dn_xfer;

   assign up_xfer = up_valid_i & up_ready_reg;
   assign dn_xfer = dn_valid_reg & dn_ready_i;

   // --------------------------------------------------------------------------
   // Next-state and payload steering
   // --------------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      main_next  = main_reg;
      skid_next  = skid_reg;

      if (flush_i) begin
         // Squash only clears validity. Payload registers are left alone and
         // any payload offered this cycle is dropped. A downstream transfer
         // happening this cycle still completes since dn_valid_o is high.
         state_next = EMPTY;
      end else begin
         unique case (state_reg)
            EMPTY: begin
               if (up_xfer) begin
                  state_next = ONE;
                  main_next  = up_data_i;
               end
            end

            ONE: begin
               unique case ({up_xfer, dn_xfer})
                  2'b11: begin
                     // Pass-through: the new payload replaces the departing one.
                     main_next = up_data_i;
                  end
                  2'b01: begin
                     state_next = EMPTY;
                  end
                  2'b10: begin
                     // Downstream stalled: park the newcomer behind main.
                     state_next = FULL;
                     skid_next  = up_data_i;
                  end
                  default: begin
                     state_next = ONE;
                  end
               endcase
            end

            FULL: begin
               // up_ready_o is low here, so only the drain case exists.
               if (dn_xfer) begin
                  state_next = ONE;
                  main_next  = skid_reg;
               end
            end

            default: begin
               // Corrupted encoding: drop everything and restart empty.
               state_next = EMPTY;
            end
         endcase
      end

      dn_valid_next = (state_next != EMPTY);
      up_ready_next = (state_next != FULL);
      occ_next      = OCC_W'(state_next);
   end

   // --------------------------------------------------------------------------
   // Registers
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg    <= EMPTY;
         main_reg     <= RESET_DATA;
         skid_reg     <= RESET_DATA;
         dn_valid_reg <= 1'b0;
         up_ready_reg <= 1'b1;
         occ_reg      <= '0;
      end else begin
         state_reg    <= state_next;
         main_reg     <= main_next;
         skid_reg     <= skid_next;
         dn_valid_reg <= dn_valid_next;
         up_ready_reg <= up_ready_next;
         occ_reg      <= occ_next;
      end
   end

   assign up_ready_o  = up_ready_reg;
   assign dn_valid_o  = dn_valid_reg;
   assign dn_data_o   = main_reg;
   assign occupancy_o = occ_reg;

   // --------------------------------------------------------------------------
   // Optional performance counters
   // --------------------------------------------------------------------------
`ifdef PIPE_STAGE_SKID_PERF_EN
   localparam int N_CNT = 2;

   // Index 0: downstream stall cycles. Index 1: flushes that hit live data.
   logic [N_CNT-1:0]     cnt_inc;
   logic [CNT_WIDTH-1:0] cnt_val [N_CNT];

   assign cnt_inc[0] = dn_valid_reg & ~dn_ready_i;
   assign cnt_inc[1] = flush_i & (occ_reg != '0);

   genvar gi;
   for (gi = 0; gi < N_CNT; gi++) begin : g_perf_cnt
      sat_counter #(
         .CNT_WIDTH (CNT_WIDTH)
      ) u_cnt (
         .clk   (clk),
         .reset (reset),
         .inc_i (cnt_inc[gi]),
         .cnt_o (cnt_val[gi])
      );
   end

   assign stall_cnt_o = cnt_val[0];
   assign flush_cnt_o = cnt_val[1];
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_skid
//   Self-checking bench for pipe_stage_skid. A queue holds every payload the
//   stage has accepted and not yet delivered; each downstream transfer pops
//   the queue front and compares it with dn_data_o. The queue length is also
//   the expected occupancy. Define PIPE_STAGE_SKID_PERF_EN to include the
//   performance counter scenario.
// -----------------------------------------------------------------------------
module tb_pipe_stage_skid;

   localparam int             DW       = 32;
   localparam logic [DW-1:0]  RST_DATA = 32'h5A5A_A5A5;
   localparam int             CW       = 4;

   logic          clk        = 1'b0;
   logic          reset      = 1'b0;
   logic          flush_i    = 1'b0;
   logic          up_valid_i = 1'b0;
   logic          dn_ready_i = 1'b0;
   logic [DW-1:0] up_data_i  = '0;
   logic          up_ready_o;
   logic          dn_valid_o;
   logic [DW-1:0] dn_data_o;
   logic [1:0]    occupancy_o;
`ifdef PIPE_STAGE_SKID_PERF_EN
   logic [CW-1:0] stall_cnt_o;
   logic [CW-1:0] flush_cnt_o;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   // Scoreboard and per-cycle observations captured by drive_cycle.
   logic [DW-1:0] sb_q[$];
   bit            fire;
   logic [DW-1:0] got;
   logic [DW-1:0] want;
   int            pre_size;
   logic [1:0]    occ_seen;
   logic          valid_seen;
   logic          ready_seen;

   always #5 clk = ~clk;

   pipe_stage_skid #(
      .DATA_WIDTH (DW),
      .RESET_DATA (RST_DATA),
      .CNT_WIDTH  (CW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .flush_i     (flush_i),
      .up_valid_i  (up_valid_i),
      .up_ready_o  (up_ready_o),
      .up_data_i   (up_data_i),
      .dn_valid_o  (dn_valid_o),
      .dn_ready_i  (dn_ready_i),
      .dn_data_o   (dn_data_o),
      .occupancy_o (occupancy_o)
`ifdef PIPE_STAGE_SKID_PERF_EN
      ,
      .stall_cnt_o (stall_cnt_o),
      .flush_cnt_o (flush_cnt_o)
`endif
   );

   // Drive one cycle of inputs on the falling edge, record what the stage
   // shows this cycle, and update the scoreboard for the coming rising edge.
   task automatic drive_cycle(input bit v, input logic [DW-1:0] d,
                              input bit r, input bit f);
      @(negedge clk);
      up_valid_i = v;
      up_data_i  = d;
      dn_ready_i = r;
      flush_i    = f;
      pre_size   = sb_q.size();
      occ_seen   = occupancy_o;
      valid_seen = dn_valid_o;
      ready_seen = up_ready_o;
      got        = dn_data_o;
      want       = 'x;
      fire       = (dn_valid_o === 1'b1) && r;
      if (fire && sb_q.size() > 0) want = sb_q.pop_front();
      if (f) sb_q.delete();
      else if (v && up_ready_o === 1'b1) sb_q.push_back(d);
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_checks++; if (dn_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", dn_valid_o); end
      n_checks++; if (up_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", up_ready_o); end
      n_checks++; if (occupancy_o !== 2'd0) begin n_fail++; $display("FAIL reset_occ: got %0d want 0", occupancy_o); end
      n_checks++; if (dn_data_o !== RST_DATA) begin n_fail++; $display("FAIL reset_data: got %h want %h", dn_data_o, RST_DATA); end
      reset = 1'b1;
      // Fill the stage, then reset mid-cycle and look before any clock edge.
      drive_cycle(1'b1, 32'h77, 1'b0, 1'b0);
      drive_cycle(1'b1, 32'h78, 1'b0, 1'b0);
      drive_cycle(1'b0, 32'h0, 1'b0, 1'b0);
      n_checks++; if (occ_seen !== 2'd2) begin n_fail++; $display("FAIL reset_prefill_occ: got %0d want 2", occ_seen); end
      #2 reset = 1'b0;
      #1;
      n_checks++; if (dn_valid_o !== 1'b0) begin n_fail++; $display("FAIL async_reset_valid: got %b want 0", dn_valid_o); end
      n_checks++; if (up_ready_o !== 1'b1) begin n_fail++; $display("FAIL async_reset_ready: got %b want 1", up_ready_o); end
      n_checks++; if (occupancy_o !== 2'd0) begin n_fail++; $display("FAIL async_reset_occ: got %0d want 0", occupancy_o); end
      n_checks++; if (dn_data_o !== RST_DATA) begin n_fail++; $display("FAIL async_reset_data: got %h want %h", dn_data_o, RST_DATA); end
      sb_q.delete();
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_streaming();
      logic [DW-1:0] vals [3] = '{32'h11, 32'h22, 32'h33};
      for (int i = 0; i < 4; i++) begin
         drive_cycle(i < 3, (i < 3) ? vals[i] : 32'h0, 1'b1, 1'b0);
         if (i > 0) begin
            n_checks++; if (!fire) begin n_fail++; $display("FAIL stream_bubble[%0d]: got valid %b want 1", i, valid_seen); end
            n_checks++; if (occ_seen !== 2'd1) begin n_fail++; $display("FAIL stream_occ[%0d]: got %0d want 1", i, occ_seen); end
         end
         if (fire) begin
            n_checks++; if (got !== want) begin n_fail++; $display("FAIL stream_data[%0d]: got %h want %h", i, got, want); end
         end
      end
      drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);
      n_checks++; if (occ_seen !== 2'd0) begin n_fail++; $display("FAIL stream_drained_occ: got %0d want 0", occ_seen); end
   endtask

   task automatic test_backpressure();
      drive_cycle(1'b1, 32'hA1, 1'b0, 1'b0);
      drive_cycle(1'b1, 32'hA2, 1'b0, 1'b0);
      drive_cycle(1'b1, 32'hEE, 1'b0, 1'b0);
      n_checks++; if (occ_seen !== 2'd2) begin n_fail++; $display("FAIL bp_occ_full: got %0d want 2", occ_seen); end
      n_checks++; if (ready_seen !== 1'b0) begin n_fail++; $display("FAIL bp_ready_full: got %b want 0", ready_seen); end
      n_checks++; if (got !== 32'hA1) begin n_fail++; $display("FAIL bp_head: got %h want a1", got); end
      drive_cycle(1'b0, 32'h0, 1'b0, 1'b0);
      n_checks++; if (got !== 32'hA1) begin n_fail++; $display("FAIL bp_hold: got %h want a1", got); end
      for (int i = 0; i < 2; i++) begin
         drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);
         n_checks++; if (!fire || got !== want) begin n_fail++; $display("FAIL bp_drain[%0d]: got %h (fire %b) want %h", i, got, fire, want); end
         if (i == 1) begin
            n_checks++; if (ready_seen !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after_pop: got %b want 1", ready_seen); end
            n_checks++; if (occ_seen !== 2'd1) begin n_fail++; $display("FAIL bp_occ_after_pop: got %0d want 1", occ_seen); end
         end
      end
      drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);
      n_checks++; if (valid_seen !== 1'b0) begin n_fail++; $display("FAIL bp_empty_valid: got %b want 0", valid_seen); end
   endtask

   task automatic test_flush();
      drive_cycle(1'b1, 32'hB1, 1'b0, 1'b0);
      drive_cycle(1'b1, 32'hB2, 1'b0, 1'b0);
      drive_cycle(1'b1, 32'hB3, 1'b0, 1'b1);
      n_checks++; if (occ_seen !== 2'd2) begin n_fail++; $display("FAIL flush_pre_occ: got %0d want 2", occ_seen); end
      for (int i = 0; i < 2; i++) begin
         drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);
         n_checks++; if (valid_seen !== 1'b0) begin n_fail++; $display("FAIL flush_valid[%0d]: got %b want 0", i, valid_seen); end
         n_checks++; if (occ_seen !== 2'd0 || ready_seen !== 1'b1) begin n_fail++; $display("FAIL flush_state[%0d]: got occ %0d ready %b want occ 0 ready 1", i, occ_seen, ready_seen); end
      end
      n_checks++; if (got !== 32'hB1) begin n_fail++; $display("FAIL flush_payload_kept: got %h want b1", got); end
      // Flush in ONE with a completing pop and a discarded offer.
      drive_cycle(1'b1, 32'hD1, 1'b0, 1'b0);
      drive_cycle(1'b1, 32'hD2, 1'b1, 1'b1);
      n_checks++; if (!fire || got !== want) begin n_fail++; $display("FAIL flush_pop: got %h (fire %b) want %h", got, fire, want); end
      drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);
      n_checks++; if (valid_seen !== 1'b0 || got !== 32'hD1) begin n_fail++; $display("FAIL flush_one_after: got valid %b data %h want valid 0 data d1", valid_seen, got); end
      // Flush while empty is harmless.
      drive_cycle(1'b0, 32'h0, 1'b1, 1'b1);
      drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);
      n_checks++; if (occ_seen !== 2'd0 || ready_seen !== 1'b1) begin n_fail++; $display("FAIL flush_empty: got occ %0d ready %b want occ 0 ready 1", occ_seen, ready_seen); end
   endtask

   task automatic test_pop_push();
      drive_cycle(1'b1, 32'hC1, 1'b0, 1'b0);
      drive_cycle(1'b1, 32'hC2, 1'b1, 1'b0);
      n_checks++; if (!fire || got !== want) begin n_fail++; $display("FAIL pp_pop: got %h (fire %b) want %h", got, fire, want); end
      drive_cycle(1'b0, 32'h0, 1'b0, 1'b0);
      n_checks++; if (occ_seen !== 2'd1) begin n_fail++; $display("FAIL pp_occ: got %0d want 1", occ_seen); end
      n_checks++; if (got !== 32'hC2) begin n_fail++; $display("FAIL pp_data: got %h want c2", got); end
      drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);
      n_checks++; if (!fire || got !== want) begin n_fail++; $display("FAIL pp_drain: got %h (fire %b) want %h", got, fire, want); end
   endtask

   task automatic test_back_to_back();
      int bad = 0;
      for (int i = 0; i < 120; i++) begin
         drive_cycle(1'($urandom_range(0, 3) != 0), DW'($urandom),
                     1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
         n_checks++;
         if (occ_seen !== 2'(pre_size) || valid_seen !== (pre_size != 0) || ready_seen !== (pre_size != 2)) begin
            n_fail++; bad++;
            if (bad < 10) $display("FAIL b2b_state[%0d]: got occ %0d valid %b ready %b want occ %0d", i, occ_seen, valid_seen, ready_seen, pre_size);
         end
         if (fire) begin
            n_checks++;
            if (got !== want) begin
               n_fail++; bad++;
               if (bad < 10) $display("FAIL b2b_data[%0d]: got %h want %h", i, got, want);
            end
         end
      end
      repeat (3) drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);
      drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);
      n_checks++; if (occ_seen !== 2'd0 || pre_size != 0) begin n_fail++; $display("FAIL b2b_drain: got occ %0d want 0", occ_seen); end
   endtask

`ifdef PIPE_STAGE_SKID_PERF_EN
   task automatic test_perf();
      int stall_exp = 0;
      reset = 1'b0;
      #1;
      n_checks++; if (stall_cnt_o !== '0 || flush_cnt_o !== '0) begin n_fail++; $display("FAIL perf_reset: got stall %0d flush %0d want 0 0", stall_cnt_o, flush_cnt_o); end
      sb_q.delete();
      @(negedge clk);
      reset = 1'b1;
      drive_cycle(1'b1, 32'hE1, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         drive_cycle(1'b0, 32'h0, 1'b0, 1'b0);
         n_checks++; if (stall_cnt_o !== CW'(stall_exp)) begin n_fail++; $display("FAIL perf_stall[%0d]: got %0d want %0d", i, stall_cnt_o, stall_exp); end
         if (valid_seen === 1'b1 && stall_exp < 15) stall_exp++;
      end
      drive_cycle(1'b0, 32'h0, 1'b0, 1'b1);
      n_checks++; if (stall_cnt_o !== 4'hF) begin n_fail++; $display("FAIL perf_stall_sat: got %h want f", stall_cnt_o); end
      n_checks++; if (flush_cnt_o !== 4'h0) begin n_fail++; $display("FAIL perf_flush_pre: got %0d want 0", flush_cnt_o); end
      drive_cycle(1'b0, 32'h0, 1'b1, 1'b1);
      n_checks++; if (flush_cnt_o !== 4'h1) begin n_fail++; $display("FAIL perf_flush: got %0d want 1", flush_cnt_o); end
      drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);
      n_checks++; if (flush_cnt_o !== 4'h1 || stall_cnt_o !== 4'hF) begin n_fail++; $display("FAIL perf_hold: got flush %0d stall %h want 1 f", flush_cnt_o, stall_cnt_o); end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_streaming();
      test_backpressure();
      test_flush();
      test_pop_push();
      test_back_to_back();
`ifdef PIPE_STAGE_SKID_PERF_EN
      test_perf();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised, flow-controlled pipeline stage register.
- Successor to the fixed IF/ID, ID/EX and EX/MEM latches in the MIPS core.
- Adds a valid/ready handshake, a two-entry skid buffer for full throughput under back-pressure, and a synchronous flush for branch/jump squash.
- Instantiated once per stage boundary; the data bus carries the packed control and datapath bundle of that stage.

Parameters:
- DATA_WIDTH, 32, width of the payload bus.
- RESET_DATA, 0, value loaded into payload registers on reset (DATA_WIDTH bits).
- CNT_WIDTH, 16, width of performance counters (used only with the optional feature).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- flush_i  input  1  synchronous squash of all held entries
- up_valid_i  input  1  upstream has a payload
- up_ready_o  output  1  stage can accept a payload this cycle
- up_data_i  input  DATA_WIDTH  upstream payload
- dn_valid_o  output  1  stage presents a payload downstream
- dn_ready_i  input  1  downstream accepts this cycle
- dn_data_o  output  DATA_WIDTH  payload presented downstream
- occupancy_o  output  2  number of valid entries held (0..2)

Behaviour:
- One clock; reset is asynchronous and active-low (clk, reset). On reset assertion, without waiting for clk:
  - state EMPTY; dn_valid_o=0; up_ready_o=1; occupancy_o=0
  - main and skid payload registers = RESET_DATA
  - dn_data_o = RESET_DATA
- Storage: main register (drives dn_data_o) and skid register. State encodes occupancy: EMPTY(0), ONE(1), FULL(2).
- up_ready_o is registered: it is 1 exactly when the state is not FULL. It is never a combinational function of dn_ready_i.
- An upstream transfer occurs when up_valid_i & up_ready_o. A downstream transfer occurs when dn_valid_o & dn_ready_i.
- Transitions, with flush_i=0:
  - EMPTY: upstream transfer → ONE, main = up_data_i; otherwise stay.
  - ONE, both transfers: stay ONE, main = up_data_i.
  - ONE, downstream transfer only: → EMPTY.
  - ONE, upstream transfer only: → FULL, skid = up_data_i.
  - ONE, neither: stay.
  - FULL, downstream transfer: → ONE, main = skid. No upstream transfer is possible in FULL.
- Latency: a payload accepted in cycle N is visible on dn_data_o with dn_valid_o=1 in cycle N+1 (1-cycle latency). Sustained throughput is 1 payload per cycle while dn_ready_i=1.
- Ordering: strict FIFO. The skid entry never overtakes main.
- dn_data_o holds its value while dn_valid_o=1 and dn_ready_i=0. Payload stability is guaranteed until the downstream transfer.
- flush_i=1 has highest priority:
  - next state EMPTY; dn_valid_o=0 and up_ready_o=1 from the next cycle.
  - any upstream payload offered in the same cycle is discarded.
  - a downstream transfer in the same cycle still completes, because dn_valid_o is already high that cycle.
  - payload registers keep their contents; only the valid state clears.
- flush_i while EMPTY: no effect beyond holding EMPTY.
- Reset mid-operation: all held entries are lost immediately, with outputs as listed above.
- occupancy_o: 0/1/2 tracking state, registered.
- Illegal state encodings: recover to EMPTY on the next clock.

Optional Feature:
- Macro: PIPE_STAGE_SKID_PERF_EN.
- When defined, two extra outputs are present:
  - stall_cnt_o [CNT_WIDTH]: increments each cycle with dn_valid_o=1 and dn_ready_i=0.
  - flush_cnt_o [CNT_WIDTH]: increments each cycle with flush_i=1 and occupancy_o>0.
- Both counters saturate at all-ones, are cleared by reset, and are not cleared by flush.
- When not defined, these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package pipe_pkg holds:
  - state enum (EMPTY=2'd0, ONE=2'd1, FULL=2'd2)
  - occupancy width constant OCC_W=2
  - saturating-increment function used by the counters
- No sub-module for the stage itself; it is a single FSM plus two registers.
- If the optional feature is built, counter logic is the natural sub-module: sat_counter, parametrised by CNT_WIDTH.

Test Plan:
- Reset check: reset low mid-stream → immediately dn_valid_o=0, up_ready_o=1, occupancy_o=0, dn_data_o=RESET_DATA.
- Streaming: dn_ready_i=1, push 0x11,0x22,0x33 on consecutive cycles → same values on dn_data_o one cycle later each, occupancy_o stays 1, no bubbles.
- Back-pressure: push 0xA1, 0xA2 with dn_ready_i=0 → occupancy_o=2, up_ready_o=0, dn_data_o=0xA1 held. Release dn_ready_i → 0xA1 then 0xA2 drain in order, up_ready_o=1 after the first pop.
- Flush while FULL (0xB1, 0xB2 held) with up_valid_i=1 offering 0xB3 → next cycle EMPTY, dn_valid_o=0, and 0xB3 never appears downstream.
- Simultaneous pop+push in ONE holding 0xC1, offering 0xC2 → next cycle occupancy_o=1, dn_data_o=0xC2.
- With PIPE_STAGE_SKID_PERF_EN and CNT_WIDTH=4: hold dn_valid_o=1, dn_ready_i=0 for 20 cycles → stall_cnt_o saturates at 0xF. One flush with an entry held → flush_cnt_o=1.
